// File: rtl/seg7_scan_decoder.sv
// Loopback monitor for a multiplexed active-low 7-segment bus: recovers one hex code per digit
// and hands out complete frames over valid/ready. Define HEX_DECODE_EN to also decode A..F.
module seg7_scan_decoder #(
    parameter int DIGITS     = 4,
    parameter int STABLE_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS-1:0]     an,
    input  logic [6:0]            seg,
    output logic [4*DIGITS-1:0]   out_data,
    output logic [DIGITS-1:0]     out_blank,
    output logic [DIGITS-1:0]     out_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun
);

    localparam int CW = $clog2(STABLE_CYC);
    localparam int SW = DIGITS + 7;
    localparam logic [0:0] ST_SETTLE = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Returns {blank, err, code}; blank and err both force the code to zero.
    function automatic logic [5:0] seg_decode(input logic [6:0] p);
        logic [5:0] r;
        case (p)
            7'b0000001: r = {2'b00, 4'h0};
            7'b1001111: r = {2'b00, 4'h1};
            7'b0010010: r = {2'b00, 4'h2};
            7'b0000110: r = {2'b00, 4'h3};
            7'b1001100: r = {2'b00, 4'h4};
            7'b0100100: r = {2'b00, 4'h5};
            7'b0100000: r = {2'b00, 4'h6};
            7'b0001111: r = {2'b00, 4'h7};
            7'b0000000: r = {2'b00, 4'h8};
            7'b0000100: r = {2'b00, 4'h9};
`ifdef HEX_DECODE_EN
            7'b0001000: r = {2'b00, 4'hA};
            7'b1100000: r = {2'b00, 4'hB};
            7'b0110001: r = {2'b00, 4'hC};
            7'b1000010: r = {2'b00, 4'hD};
            7'b0110000: r = {2'b00, 4'hE};
            7'b0111000: r = {2'b00, 4'hF};
`endif
            7'b1111111: r = {2'b10, 4'h0};
            default:    r = {2'b01, 4'h0};
        endcase
        return r;
    endfunction

    logic [DIGITS-1:0]   r_an_m, r_an_s;
    logic [6:0]          r_seg_m, r_seg_s;
    logic [SW-1:0]       r_prev;
    logic [0:0]          r_state;
    logic [CW-1:0]       r_cnt;
    logic [DIGITS-1:0]   r_seen;
    logic [4*DIGITS-1:0] r_sh_code;
    logic [DIGITS-1:0]   r_sh_blank, r_sh_err;
    logic [4*DIGITS-1:0] r_out_data;
    logic [DIGITS-1:0]   r_out_blank, r_out_err;
    logic                r_out_valid, r_overrun;

    logic [SW-1:0]       w_sample;
    logic [DIGITS-1:0]   w_sel;
    logic                w_legal, w_same, w_cap, w_complete, w_free;
    logic [0:0]          w_state_n;
    logic [CW-1:0]       w_cnt_n;
    logic [5:0]          w_dec;
    logic [DIGITS-1:0]   w_seen_n, w_blank_n, w_err_n;
    logic [4*DIGITS-1:0] w_code_n;

    // Two-flop synchronizers on the display bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an_m  <= '1;
            r_an_s  <= '1;
            r_seg_m <= 7'h7F;
            r_seg_s <= 7'h7F;
        end else begin
            r_an_m  <= an;
            r_an_s  <= r_an_m;
            r_seg_m <= seg;
            r_seg_s <= r_seg_m;
        end
    end

    // Stability tracking: a digit is captured once per stable period, then locked out.
    always_comb begin
        w_sample  = {r_an_s, r_seg_s};
        w_sel     = ~r_an_s;
        w_legal   = (w_sel != '0) && ((w_sel & (w_sel - DIGITS'(1))) == '0);
        w_same    = (w_sample == r_prev);
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_cap     = 1'b0;
        if (!w_legal || !w_same) begin
            w_state_n = ST_SETTLE;
            w_cnt_n   = '0;
        end else begin
            case (r_state)
                ST_SETTLE: begin
                    if (r_cnt == CW'(STABLE_CYC - 2)) begin
                        w_cap     = 1'b1;
                        w_state_n = ST_LOCKED;
                        w_cnt_n   = r_cnt + CW'(1);
                    end else begin
                        w_cnt_n   = r_cnt + CW'(1);
                    end
                end
                ST_LOCKED: begin
                    w_cnt_n = r_cnt;
                end
                default: begin
                    w_state_n = ST_SETTLE;
                    w_cnt_n   = '0;
                end
            endcase
        end
    end

    // Shadow frame update; the completing capture is folded in so the output loads it directly.
    always_comb begin
        w_dec     = seg_decode(r_seg_s);
        w_code_n  = r_sh_code;
        w_blank_n = r_sh_blank;
        w_err_n   = r_sh_err;
        w_seen_n  = r_seen;
        for (int i = 0; i < DIGITS; i++) begin
            w_code_n[4*i +: 4] = (w_cap && w_sel[i]) ? w_dec[3:0] : r_sh_code[4*i +: 4];
            w_blank_n[i]       = (w_cap && w_sel[i]) ? w_dec[5]   : r_sh_blank[i];
            w_err_n[i]         = (w_cap && w_sel[i]) ? w_dec[4]   : r_sh_err[i];
            w_seen_n[i]        = (w_cap && w_sel[i]) ? 1'b1       : r_seen[i];
        end
        w_complete = w_cap && (&w_seen_n);
        w_free     = !r_out_valid || out_ready;
    end

    // Scan state and shadow frame registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev     <= '1;
            r_state    <= ST_SETTLE;
            r_cnt      <= '0;
            r_seen     <= '0;
            r_sh_code  <= '0;
            r_sh_blank <= '0;
            r_sh_err   <= '0;
        end else begin
            r_prev     <= w_sample;
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_seen     <= w_complete ? '0 : w_seen_n;
            r_sh_code  <= w_code_n;
            r_sh_blank <= w_blank_n;
            r_sh_err   <= w_err_n;
        end
    end

    // Output frame with valid/ready handshake; a frame completing while busy is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_blank <= '0;
            r_out_err   <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= w_complete && !w_free;
            if (w_complete && w_free) begin
                r_out_data  <= w_code_n;
                r_out_blank <= w_blank_n;
                r_out_err   <= w_err_n;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= r_out_valid;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_blank = r_out_blank;
    assign out_err   = r_out_err;
    assign out_valid = r_out_valid;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed plus randomized bench for seg7_scan_decoder against a frame-level reference model.
module tb_seg7_scan_decoder;

    localparam int DIGITS     = 4;
    localparam int STABLE_CYC = 16;
    localparam int LONG       = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  an = 4'hF;
    logic [6:0]  seg = 7'h7F;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [3:0]  out_blank, out_err;
    logic        out_valid, overrun;

    seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYC(STABLE_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .an(an), .seg(seg),
        .out_data(out_data), .out_blank(out_blank), .out_err(out_err),
        .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  b;
        logic [3:0]  e;
    } frame_t;

    logic [6:0] pat [0:15] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                               7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    frame_t acc_q[$];
    frame_t exp_q[$];
    int checks = 0, errors = 0;
    int valid_cyc = 0, ovr_cnt = 0;

    frame_t      m_sh, m_out;
    logic [3:0]  m_seen;
    logic        m_valid;
    int          m_ovr;
    logic [10:0] m_last;

    // Observe handshakes and overrun pulses between clock edges.
    always @(negedge clk) begin
        if (out_valid) valid_cyc++;
        if (out_valid && out_ready) acc_q.push_back({out_data, out_blank, out_err});
        if (overrun) ovr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] ref_decode(input logic [6:0] p);
        int n = 10;
`ifdef HEX_DECODE_EN
        n = 16;
`endif
        if (p == 7'h7F) return 6'b100000;
        for (int k = 0; k < n; k++)
            if (pat[k] == p) return {2'b00, 4'(k)};
        return 6'b010000;
    endfunction

    task automatic model_reset();
        m_sh = '0; m_out = '0; m_seen = '0; m_valid = 1'b0; m_last = 11'h7FF;
    endtask

    task automatic capture(input int slot, input logic [6:0] s);
        logic [5:0] dec;
        dec = ref_decode(s);
        m_sh.d[4*slot +: 4] = dec[3:0];
        m_sh.b[slot] = dec[5];
        m_sh.e[slot] = dec[4];
        m_seen[slot] = 1'b1;
        if (&m_seen) begin
            m_seen = '0;
            if (m_valid && !out_ready) m_ovr++;
            else begin
                m_out = m_sh;
                if (out_ready) exp_q.push_back(m_sh);
                else m_valid = 1'b1;
            end
        end
    endtask

    // Hold {a,s} on the pins for n cycles; long distinct legal holds are captures.
    task automatic show(input logic [3:0] a, input logic [6:0] s, input int n);
        an = a; seg = s;
        if (n >= LONG && $countones(~a) == 1 && {a, s} != m_last)
            for (int k = 0; k < 4; k++) if (!a[k]) capture(k, s);
        m_last = {a, s};
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show_digit(input int slot, input logic [6:0] s);
        logic [3:0] one;
        one = 4'b0001;
        show(~(one << slot), s, LONG);
    endtask

    task automatic set_ready(input logic r);
        out_ready = r;
        if (r && m_valid) begin
            exp_q.push_back(m_out);
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_frames(input string tag);
        int n;
        check({tag, "_count"}, acc_q.size(), exp_q.size());
        n = (acc_q.size() < exp_q.size()) ? acc_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_frame"}, 32'(acc_q[i]), 32'(exp_q[i]));
        acc_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int v0, o0;
        model_reset();
        m_ovr = 0;
        #2;
        check("rst_data", 32'(out_data), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_flags", 32'({out_blank, out_err, overrun}), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // 1: plain scan of 1,2,3,4
        v0 = valid_cyc;
        for (int i = 0; i < 4; i++) show_digit(i, pat[i+1]);
        repeat (2) @(posedge clk); #1;
        check("t1_data", 32'(out_data), 32'h4321);
        check("t1_valid_width", 32'(valid_cyc - v0), 32'd1);
        compare_frames("t1");

        // 2: back-pressure across two scans
        set_ready(1'b0);
        o0 = ovr_cnt;
        for (int i = 0; i < 4; i++) show_digit(i, pat[i+5]);
        check("t2_valid_held", 32'(out_valid), 32'h1);
        check("t2_first_data", 32'(out_data), 32'(m_out.d));
        for (int i = 0; i < 4; i++) show_digit(i, pat[(i+9) % 10]);
        check("t2_overrun", 32'(ovr_cnt - o0), 32'd1);
        check("t2_data_kept", 32'(out_data), 32'(m_out.d));
        set_ready(1'b1);
        @(negedge clk);
        check("t2_valid_at_accept", 32'(out_valid), 32'h1);
        @(negedge clk);
        check("t2_valid_drop", 32'(out_valid), 32'h0);
        @(posedge clk); #1;
        compare_frames("t2");

        // 3: short glitch and two-digit-enable period are never captured
        show_digit(0, pat[3]);
        show_digit(1, pat[7]);
        show(4'b1101, pat[8], 10);
        show_digit(1, pat[7]);
        show(4'b0011, pat[1], 40);
        check("t3_no_frame", 32'(acc_q.size()), 32'd0);
        show_digit(2, pat[0]);
        show_digit(3, pat[9]);
        repeat (2) @(posedge clk); #1;
        check("t3_data", 32'(out_data), 32'h9073);
        compare_frames("t3");

        // 4: blank and undecodable digits
        show_digit(0, pat[6]);
        show_digit(1, 7'b1010101);
        show_digit(2, 7'b1111111);
        show_digit(3, pat[2]);
        repeat (2) @(posedge clk); #1;
        check("t4_blank", 32'(out_blank), 32'h4);
        check("t4_err", 32'(out_err), 32'h2);
        compare_frames("t4");

        // 5: hex-only pattern on digit 0
        show_digit(0, 7'b0001000);
        for (int i = 1; i < 4; i++) show_digit(i, pat[i]);
        repeat (2) @(posedge clk); #1;
`ifdef HEX_DECODE_EN
        check("t5_code", 32'({out_data[3:0], out_err[0]}), 32'h14);
`else
        check("t5_code", 32'({out_data[3:0], out_err[0]}), 32'h01);
`endif
        compare_frames("t5");

        // 6: reset with a partial frame, then a clean scan
        for (int i = 0; i < 3; i++) show_digit(i, pat[i+4]);
        rst_n = 1'b0; an = 4'hF; seg = 7'h7F;
        #1;
        check("t6_rst_data", 32'(out_data), 32'h0);
        check("t6_rst_valid", 32'(out_valid), 32'h0);
        model_reset();
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        o0 = ovr_cnt;
        for (int i = 0; i < 4; i++) show_digit(i, pat[9-i]);
        repeat (2) @(posedge clk); #1;
        check("t6_data", 32'(out_data), 32'h6789);
        check("t6_no_overrun", 32'(ovr_cnt - o0), 32'd0);
        compare_frames("t6");

        // Randomized scan traffic with glitches and back-pressure
        for (int step = 0; step < 60; step++) begin
            int r;
            logic [6:0] s;
            r = $urandom_range(0, 9);
            case ($urandom_range(0, 5))
                0: s = 7'h7F;
                1: s = 7'($urandom());
                default: s = pat[$urandom_range(0, 15)];
            endcase
            if (r == 0) show(4'($urandom()), s, $urandom_range(1, 10));
            else if (r == 1) set_ready(1'($urandom_range(0, 1)));
            else begin
                logic [3:0] one;
                one = 4'b0001;
                show(~(one << $urandom_range(0, 3)), s, $urandom_range(LONG, LONG + 6));
            end
        end
        set_ready(1'b1);
        repeat (4) @(posedge clk); #1;
        compare_frames("rand");
        check("rand_overruns", 32'(ovr_cnt), 32'(m_ovr));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
